// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU scheduler: FSM state encoding, opcode map and result width.
// Also holds a behavioural reference of the shared ALU for use by environment models.
package alu_sched_pkg;

  localparam int OPND_W = 8;
  localparam int INST_W = 3;
  localparam int RES_W  = 16;

  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'd0,
    ST_DRAINING = 2'd1,
    ST_HALTED   = 2'd2
  } state_e;

  localparam logic [INST_W-1:0] OP_ADD  = 3'd0;
  localparam logic [INST_W-1:0] OP_SUB  = 3'd1;
  localparam logic [INST_W-1:0] OP_AND  = 3'd2;
  localparam logic [INST_W-1:0] OP_OR   = 3'd3;
  localparam logic [INST_W-1:0] OP_XOR  = 3'd4;
  localparam logic [INST_W-1:0] OP_MUL  = 3'd5;
  localparam logic [INST_W-1:0] OP_SHL  = 3'd6;
  localparam logic [INST_W-1:0] OP_PASS = 3'd7;

  // Operands are zero-extended to the result width before every operation.
  function automatic logic [RES_W-1:0] alu_ref(input logic [OPND_W-1:0] a,
                                               input logic [OPND_W-1:0] b,
                                               input logic [INST_W-1:0] inst);
    logic [RES_W-1:0] ea;
    logic [RES_W-1:0] eb;
    logic [RES_W-1:0] res;
    ea  = {{(RES_W-OPND_W){1'b0}}, a};
    eb  = {{(RES_W-OPND_W){1'b0}}, b};
    res = '0;
    case (inst)
      OP_ADD:  res = ea + eb;
      OP_SUB:  res = ea - eb;
      OP_AND:  res = ea & eb;
      OP_OR:   res = ea | eb;
      OP_XOR:  res = ea ^ eb;
      OP_MUL:  res = ea * eb;
      OP_SHL:  res = ea << b[3:0];
      OP_PASS: res = ea;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_sched_rr_arb.sv
// Two-way round-robin arbiter: combinational grant, pointer remembers the last winner.
// Pointer resets to requester 1 so requester 0 wins the first tie.
module alu_rr_arb
  import alu_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = r_ptr ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  // Any grant is an acceptance, so the pointer only moves when an operation is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b1;
    end else if (|o_gnt) begin
      r_ptr <= o_gnt[1];
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Schedules two requesters onto one shared pipelined ALU, tracking issued operations
// with an in-flight tag shift register and supporting halt/drain.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int ALU_LAT = 2
) (
  input  logic              clk_p_i,
  input  logic              reset_n_i,
  input  logic              req0_valid_i,
  input  logic              req1_valid_i,
  output logic              req0_ready_o,
  output logic              req1_ready_o,
  input  logic [7:0]        req0_a_i,
  input  logic [7:0]        req0_b_i,
  input  logic [7:0]        req1_a_i,
  input  logic [7:0]        req1_b_i,
  input  logic [2:0]        req0_inst_i,
  input  logic [2:0]        req1_inst_i,
  output logic [7:0]        alu_a_o,
  output logic [7:0]        alu_b_o,
  output logic [2:0]        alu_inst_o,
  input  logic [RES_W-1:0]  alu_data_i,
  output logic              rsp_valid_o,
  output logic              rsp_id_o,
  output logic [RES_W-1:0]  rsp_data_o,
  input  logic              halt_i,
  output logic              halted_o,
  output logic [15:0]       op_cnt_o
);

  state_e            r_state;
  logic              r_halted;
  logic [ALU_LAT:0]  r_tag_vld;
  logic [ALU_LAT:0]  r_tag_id;
  logic [7:0]        r_alu_a;
  logic [7:0]        r_alu_b;
  logic [2:0]        r_alu_inst;
  logic              r_rsp_vld;
  logic              r_rsp_id;
  logic [RES_W-1:0]  r_rsp_data;
  logic [15:0]       r_op_cnt;

  logic [1:0]        w_gnt;
  logic              w_en;
  logic              w_accept;
  logic              w_gnt_id;

  // halt_i gates issue combinationally so the cycle it rises already grants nothing.
  assign w_en     = (r_state == ST_ACTIVE) && !halt_i;
  assign w_accept = |w_gnt;
  assign w_gnt_id = w_gnt[1];

  alu_rr_arb u_arb (
    .clk   (clk_p_i),
    .rst_n (reset_n_i),
    .i_req ({req1_valid_i, req0_valid_i}),
    .i_en  (w_en),
    .o_gnt (w_gnt)
  );

  assign req0_ready_o = w_gnt[0];
  assign req1_ready_o = w_gnt[1];

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_inst <= '0;
      r_op_cnt   <= '0;
    end else if (w_accept) begin
      r_alu_a    <= w_gnt_id ? req1_a_i    : req0_a_i;
      r_alu_b    <= w_gnt_id ? req1_b_i    : req0_b_i;
      r_alu_inst <= w_gnt_id ? req1_inst_i : req0_inst_i;
      r_op_cnt   <= r_op_cnt + 16'd1;
    end
  end

  // Tag stage k holds the operation issued k+1 edges ago; the last stage lines up with alu_data_i.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_tag_vld  <= '0;
      r_tag_id   <= '0;
      r_rsp_vld  <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[ALU_LAT-1:0], w_accept};
      r_tag_id  <= {r_tag_id[ALU_LAT-1:0], w_gnt_id};
      r_rsp_vld <= r_tag_vld[ALU_LAT];
      if (r_tag_vld[ALU_LAT]) begin
        r_rsp_id   <= r_tag_id[ALU_LAT];
        r_rsp_data <= alu_data_i;
      end
    end
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= ST_ACTIVE;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_ACTIVE: begin
          if (halt_i) r_state <= ST_DRAINING;
        end
        ST_DRAINING: begin
          if (!halt_i) begin
            r_state <= ST_ACTIVE;
          end else if (r_tag_vld == '0) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (!halt_i) begin
            r_state  <= ST_ACTIVE;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_ACTIVE;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a_o     = r_alu_a;
  assign alu_b_o     = r_alu_b;
  assign alu_inst_o  = r_alu_inst;
  assign rsp_valid_o = r_rsp_vld;
  assign rsp_id_o    = r_rsp_id;
  assign rsp_data_o  = r_rsp_data;
  assign halted_o    = r_halted;
  assign op_cnt_o    = r_op_cnt;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with an external two-register ALU model (ALU_LAT=2).
module tb_alu_sched;
  import alu_sched_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_inst, req1_inst;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_inst;
  logic [15:0] alu_data;
  logic        rsp_valid, rsp_id;
  logic [15:0] rsp_data;
  logic        halt, halted;
  logic [15:0] op_cnt;

  logic [15:0] alu_p1, alu_p2;
  int          n_vec;
  int          n_err;
  logic        seen_rsp;

  alu_sched #(.ALU_LAT(2)) dut (
    .clk_p_i      (clk),
    .reset_n_i    (reset_n),
    .req0_valid_i (req0_valid),
    .req1_valid_i (req1_valid),
    .req0_ready_o (req0_ready),
    .req1_ready_o (req1_ready),
    .req0_a_i     (req0_a),
    .req0_b_i     (req0_b),
    .req1_a_i     (req1_a),
    .req1_b_i     (req1_b),
    .req0_inst_i  (req0_inst),
    .req1_inst_i  (req1_inst),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_inst_o   (alu_inst),
    .alu_data_i   (alu_data),
    .rsp_valid_o  (rsp_valid),
    .rsp_id_o     (rsp_id),
    .rsp_data_o   (rsp_data),
    .halt_i       (halt),
    .halted_o     (halted),
    .op_cnt_o     (op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: captures the driven operands one edge after issue, result stable one edge later.
  always @(posedge clk) begin
    alu_p1 <= alu_ref(alu_a, alu_b, alu_inst);
    alu_p2 <= alu_p1;
  end
  assign alu_data = alu_p2;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset_n = 1'b0; halt = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_inst = '0;
    req1_a = '0; req1_b = '0; req1_inst = '0;
    alu_p1 = '0; alu_p2 = '0;
    #12;
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_inst", alu_inst, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_op_cnt", op_cnt, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    reset_n = 1'b1;

    // Tie: both valid for four cycles, requester 0 first
    #1;
    req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h01; req0_inst = OP_ADD;
    req1_valid = 1'b1; req1_a = 8'h20; req1_b = 8'h02; req1_inst = OP_SUB;
    #1; chk("tie_g0", {req1_ready, req0_ready}, 2'b01);
    tick(); chk("tie_g1", {req1_ready, req0_ready}, 2'b10);
    tick(); chk("tie_g2", {req1_ready, req0_ready}, 2'b01);
    tick(); chk("tie_g3", {req1_ready, req0_ready}, 2'b10);
    tick(); req0_valid = 1'b0; req1_valid = 1'b0;
    chk("tie_cnt", op_cnt, 4);
    chk("tie_r0", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, 16'h0011});
    tick(); chk("tie_r1", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b1, 16'h001E});
    tick(); chk("tie_r2", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, 16'h0011});
    tick(); chk("tie_r3", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b1, 16'h001E});
    tick(); chk("tie_end", rsp_valid, 0);

    // Stall: req1 waits one cycle behind req0
    req0_valid = 1'b1; req0_a = 8'h07; req0_b = 8'h09; req0_inst = OP_ADD;
    req1_valid = 1'b1; req1_a = 8'h30; req1_b = 8'h04; req1_inst = OP_OR;
    #1; chk("stall_g0", {req1_ready, req0_ready}, 2'b01);
    tick(); req0_valid = 1'b0;
    #1; chk("stall_g1", {req1_ready, req0_ready}, 2'b10);
    chk("stall_alu0", {alu_a, alu_b, alu_inst}, {8'h07, 8'h09, 3'd0});
    tick(); req1_valid = 1'b0;
    chk("stall_alu1", {alu_a, alu_b, alu_inst}, {8'h30, 8'h04, 3'd3});
    tick(); chk("stall_wait", rsp_valid, 0);
    tick(); chk("stall_r0", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, 16'h0010});
    tick(); chk("stall_r1", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b1, 16'h0034});
    tick(); chk("stall_end", rsp_valid, 0);

    // Single issue: 5 + 3, response three edges after acceptance
    req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h03; req0_inst = OP_ADD;
    #1; chk("single_rdy", {req1_ready, req0_ready}, 2'b01);
    tick(); req0_valid = 1'b0;
    chk("single_alu", {alu_a, alu_b, alu_inst}, {8'h05, 8'h03, 3'd0});
    chk("single_cnt", op_cnt, 7);
    tick(); chk("single_e1", rsp_valid, 0);
    tick(); chk("single_e2", rsp_valid, 0);
    tick(); chk("single_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 1'b0, 16'h0008});
    tick(); chk("single_hold", {rsp_valid, rsp_id, rsp_data}, {1'b0, 1'b0, 16'h0008});

    // Halt after two back-to-back issues
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01; req0_inst = OP_ADD;
    tick(); tick();
    halt = 1'b1;
    #1; chk("halt_rdy_now", req0_ready, 0);
    tick(); chk("halt_drain", {req0_ready, halted}, 2'b00);
    tick(); chk("halt_r0", {rsp_valid, rsp_data, halted}, {1'b1, 16'h0002, 1'b0});
    tick(); chk("halt_r1", {rsp_valid, rsp_data, halted}, {1'b1, 16'h0002, 1'b0});
    tick(); chk("halt_halted", {rsp_valid, halted, req0_ready}, {1'b0, 1'b1, 1'b0});
    halt = 1'b0;
    #1; chk("halt_still", {halted, req0_ready}, 2'b10);
    tick(); chk("halt_resume", {halted, req0_ready}, 2'b01);
    tick(); req0_valid = 1'b0;
    chk("halt_cnt", op_cnt, 10);
    repeat (4) tick();

    // Reset while two operations are in flight
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_inst = OP_ADD;
    tick(); tick(); req0_valid = 1'b0;
    chk("mid_pre", {alu_a, op_cnt}, {8'h11, 16'd12});
    tick();
    reset_n = 1'b0;
    #1;
    chk("mid_alu", {alu_a, alu_b, alu_inst}, 0);
    chk("mid_rsp", {rsp_valid, rsp_id, rsp_data}, 0);
    chk("mid_cnt_halt", {op_cnt, halted}, 0);
    tick();
    reset_n = 1'b1;
    seen_rsp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid) seen_rsp = 1'b1;
    end
    chk("mid_no_rsp", seen_rsp, 0);

    // Counter wrap: 65536 consecutive acceptances
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_inst = OP_ADD;
    repeat (65535) tick();
    chk("wrap_max", op_cnt, 16'hFFFF);
    tick();
    chk("wrap_zero", op_cnt, 16'h0000);
    req0_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 SHALL have parameter ALU_LAT, default 2, meaning clock edges from the ALU capturing its inputs to alu_data_i being valid; legal range 1..4.
REQ-002 SHALL have port clk_p_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n_i  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports req0_valid_i / req1_valid_i  input  1  requester 0/1 has an operation pending.
REQ-005 SHALL have ports req0_ready_o / req1_ready_o  output  1  operation accepted this cycle.
REQ-006 SHALL have ports req0_a_i, req0_b_i, req1_a_i, req1_b_i  input  8  operands, and req0_inst_i, req1_inst_i  input  3  opcode.
REQ-007 SHALL have ports alu_a_o, alu_b_o  output  8  and alu_inst_o  output  3  registered drive to the shared ALU.
REQ-008 SHALL have port alu_data_i  input  16  ALU result.
REQ-009 SHALL have ports rsp_valid_o  output  1, rsp_id_o  output  1  (requester index), rsp_data_o  output  16.
REQ-010 SHALL have port halt_i  input  1  request to stop issuing, and halted_o  output  1  pipeline empty and stopped.
REQ-011 SHALL have port op_cnt_o  output  16  count of accepted operations.

Function
REQ-012 Handshake: an operation is accepted on a rising edge where reqN_valid_i=1 and reqN_ready_o=1; reqN_ready_o SHALL be combinational from valids, state and arbitration pointer; at most one ready is high per cycle.
REQ-013 Requesters hold operands/opcode stable while valid=1 and ready=0; the block SHALL tolerate valid dropping without acceptance.
REQ-014 Arbitration SHALL be round-robin: with one valid, grant it; with both valid, grant the requester not granted last; pointer updates only on acceptance.
REQ-015 On acceptance at edge E, alu_a_o/alu_b_o/alu_inst_o SHALL load the granted operands at E; with no acceptance they SHALL hold their previous values.
REQ-016 An in-flight tag (valid, id) shift register of depth ALU_LAT+1 SHALL track each issue; at edge E+ALU_LAT+1 rsp_data_o SHALL load alu_data_i, rsp_id_o the tag id, and rsp_valid_o=1 for exactly one cycle.
REQ-017 Default latency (ALU_LAT=2): acceptance at edge E, rsp_valid_o high in the cycle after edge E+3; throughput one operation per cycle, no response back-pressure.
REQ-018 Responses SHALL return in acceptance order; rsp_id_o/rsp_data_o hold their last values when rsp_valid_o=0.
REQ-019 FSM states ACTIVE, DRAINING, HALTED: ACTIVE->DRAINING when halt_i=1; DRAINING->HALTED when no tag valid; HALTED->ACTIVE when halt_i=0; DRAINING->ACTIVE if halt_i drops before empty.
REQ-020 No grant SHALL occur in DRAINING or HALTED, including the cycle halt_i first rises (halt_i qualifies ready combinationally); in-flight operations SHALL complete normally.
REQ-021 halted_o SHALL be 1 exactly while state=HALTED.
REQ-022 op_cnt_o SHALL increment by 1 per acceptance and wrap 0xFFFF->0x0000.

Reset
REQ-023 On reset_n_i=0, all outputs and state SHALL clear immediately: alu_* = 0, rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, op_cnt_o=0, halted_o=0, state=ACTIVE, tags invalid, RR pointer = 1 (requester 0 wins first tie).
REQ-024 Reset mid-operation SHALL discard all in-flight tags; no response for them after release.

Structure
REQ-025 Shared package SHALL hold the FSM state encoding, the 3-bit opcode constants, and the 16-bit result width constant.
REQ-026 Round-robin arbitration SHALL be a sub-module alu_rr_arb (2 requests, grant vector, pointer register).

Verification
REQ-027 Single issue: req0 a=0x05, b=0x03, inst=000, ALU model returns 0x0008 -> rsp_valid_o 3 cycles after accept, rsp_id_o=0, rsp_data_o=0x0008.
REQ-028 Tie: both valid for 4 cycles after reset -> grants 0,1,0,1; responses ids 0,1,0,1 on consecutive cycles.
REQ-029 Halt: issue back-to-back, raise halt_i -> no ready that cycle onward, remaining responses arrive, halted_o=1 the cycle after last tag clears; drop halt_i -> grants resume next cycle.
REQ-030 Reset mid-flight: accept 2 ops, assert reset_n_i=0 one cycle later -> outputs 0 immediately, no rsp_valid_o after release.
REQ-031 Counter wrap: force 65536 acceptances -> op_cnt_o returns to 0x0000.
REQ-032 Stall: req1 valid with ready low (req0 favoured) -> req1 fields held, accepted next cycle, correct rsp_data_o.
